// File: rtl/expr_matcher.sv
// expr_matcher: streaming recogniser for ASCII arithmetic expressions with
// multi-digit operands, nested parentheses and '=' terminated expression counting.
module expr_matcher #(
    parameter int         MAX_DIGITS = 4,
    parameter int         MAX_DEPTH  = 7,
    parameter logic [3:0] OP_MASK    = 4'b1111,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [7:0]       in,
    input  logic             in_valid,
    output logic             out,
    output logic             err,
    output logic             done,
    output logic [3:0]       depth,
    output logic [CNT_W-1:0] expr_cnt
);
    typedef enum logic [1:0] {EXPECT, NUM, CLOSE, ERR} state_t;

    state_t           state_q, state_d;
    logic [3:0]       depth_q, depth_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] expr_cnt_q, expr_cnt_d;

    logic is_dig, is_opr, is_lp, is_rp, is_eq;

    always_comb begin
        is_dig = in >= 8'h30 && in <= 8'h39;
        is_opr = (in == 8'h2b && OP_MASK[0]) || (in == 8'h2d && OP_MASK[1]) ||
                 (in == 8'h2a && OP_MASK[2]) || (in == 8'h2f && OP_MASK[3]);
        is_lp  = in == 8'h28;
        is_rp  = in == 8'h29;
        is_eq  = in == 8'h3d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= EXPECT;
            depth_q    <= '0;
            cnt_q      <= '0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            expr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            expr_cnt_q <= expr_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                EXPECT: state_d = is_dig ? NUM :
                                  (is_lp && depth_q != 4'(MAX_DEPTH)) ? EXPECT : ERR;
                NUM: state_d = is_dig ? ((zero_q || cnt_q == 4'(MAX_DIGITS)) ? ERR : NUM) :
                               is_opr ? EXPECT :
                               is_rp  ? (depth_q == 4'd0 ? ERR : CLOSE) :
                               is_eq  ? (depth_q == 4'd0 ? EXPECT : ERR) : ERR;
                CLOSE: state_d = is_opr ? EXPECT :
                                 is_rp  ? (depth_q == 4'd0 ? ERR : CLOSE) :
                                 is_eq  ? (depth_q == 4'd0 ? EXPECT : ERR) : ERR;
                default: state_d = ERR;
            endcase
        end
    end

    // Only legal transitions update the datapath, so ERR freezes everything.
    always_comb begin
        depth_d    = depth_q;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        expr_cnt_d = expr_cnt_q;
        if (in_valid && state_d != ERR) begin
            if (is_lp) depth_d = depth_q + 4'd1;
            if (is_rp) depth_d = depth_q - 4'd1;
            if (is_dig) begin
                cnt_d  = state_q == NUM ? cnt_q + 4'd1 : 4'd1;
                zero_d = state_q == EXPECT && in == 8'h30;
            end
            if (is_eq) begin
                done_d     = 1'b1;
                expr_cnt_d = expr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out      = (state_q == NUM || state_q == CLOSE) && depth_q == 4'd0;
        err      = state_q == ERR;
        done     = done_q;
        depth    = depth_q;
        expr_cnt = expr_cnt_q;
    end
endmodule

// File: tb/tb_expr_matcher.sv
// tb_expr_matcher: directed vectors against default, MAX_DEPTH=2 and OP_MASK=0101 instances.
module tb_expr_matcher;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;

    logic       out_a, err_a, done_a;
    logic [3:0] depth_a;
    logic [7:0] cnt_a;
    logic       out_b, err_b, done_b;
    logic [3:0] depth_b;
    logic [7:0] cnt_b;
    logic       out_c, err_c, done_c;
    logic [3:0] depth_c;
    logic [7:0] cnt_c;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    expr_matcher u_def (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .out(out_a), .err(err_a), .done(done_a), .depth(depth_a), .expr_cnt(cnt_a)
    );

    expr_matcher #(.MAX_DEPTH(2)) u_d2 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .out(out_b), .err(err_b), .done(done_b), .depth(depth_b), .expr_cnt(cnt_b)
    );

    expr_matcher #(.OP_MASK(4'b0101)) u_m5 (
        .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
        .out(out_c), .err(err_c), .done(done_c), .depth(depth_c), .expr_cnt(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] c);
        in = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in = 8'h00;
    endtask

    task automatic idle(input logic [7:0] junk);
        in = junk;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    // send one char on the default instance and check out/err
    task automatic step(input logic [7:0] c, input logic eo, input logic ee, input string tag);
        send(c);
        chk({tag, ".out"}, 32'(out_a), 32'(eo));
        chk({tag, ".err"}, 32'(err_a), 32'(ee));
    endtask

    initial begin
        do_clr();
        chk("rst.out", 32'(out_a), 0);
        chk("rst.err", 32'(err_a), 0);
        chk("rst.done", 32'(done_a), 0);
        chk("rst.depth", 32'(depth_a), 0);
        chk("rst.cnt", 32'(cnt_a), 0);

        // 1: "1+2*3"
        step("1", 1, 0, "t1.1");
        step("+", 0, 0, "t1.+");
        step("2", 1, 0, "t1.2");
        step("*", 0, 0, "t1.*");
        step("3", 1, 0, "t1.3");
        chk("t1.depth", 32'(depth_a), 0);

        // 2: "(12+3)*4=" then "5="
        do_clr();
        step("(", 0, 0, "t2.(");
        chk("t2.depth1", 32'(depth_a), 1);
        step("1", 0, 0, "t2.1");
        step("2", 0, 0, "t2.2");
        step("+", 0, 0, "t2.+");
        step("3", 0, 0, "t2.3");
        step(")", 1, 0, "t2.)");
        chk("t2.depth0", 32'(depth_a), 0);
        step("*", 0, 0, "t2.*");
        step("4", 1, 0, "t2.4");
        chk("t2.done_pre", 32'(done_a), 0);
        step("=", 0, 0, "t2.=");
        chk("t2.done", 32'(done_a), 1);
        chk("t2.cnt1", 32'(cnt_a), 1);
        idle(8'h3d);
        chk("t2.done_drop", 32'(done_a), 0);
        chk("t2.out_idle", 32'(out_a), 0);
        chk("t2.cnt_hold", 32'(cnt_a), 1);
        step("5", 1, 0, "t2.5");
        step("=", 0, 0, "t2.=2");
        chk("t2.done2", 32'(done_a), 1);
        chk("t2.cnt2", 32'(cnt_a), 2);

        // 3: operand overflow, sticky error, async clear
        step("1", 1, 0, "t3.1");
        step("2", 1, 0, "t3.2");
        step("3", 1, 0, "t3.3");
        step("4", 1, 0, "t3.4");
        step("5", 0, 1, "t3.5");
        step("+", 0, 1, "t3.+");
        step("1", 0, 1, "t3.1b");
        chk("t3.cnt_frozen", 32'(cnt_a), 2);
        #2;
        clr = 1'b1;
        #1;
        chk("t3.aclr.err", 32'(err_a), 0);
        chk("t3.aclr.out", 32'(out_a), 0);
        chk("t3.aclr.depth", 32'(depth_a), 0);
        chk("t3.aclr.cnt", 32'(cnt_a), 0);
        clr = 1'b0;
        step("7", 1, 0, "t3.7");

        // 4: depth limit on MAX_DEPTH=2 instance, unbalanced strings
        do_clr();
        send("(");
        send("(");
        chk("t4.d2.depth", 32'(depth_b), 2);
        chk("t4.d2.err_pre", 32'(err_b), 0);
        send("(");
        chk("t4.d2.err", 32'(err_b), 1);
        chk("t4.d2.depth_frozen", 32'(depth_b), 2);
        chk("t4.def.depth3", 32'(depth_a), 3);
        chk("t4.def.err", 32'(err_a), 0);
        do_clr();
        step("1", 1, 0, "t4.1");
        step(")", 0, 1, "t4.)");
        do_clr();
        step("(", 0, 0, "t4.(");
        step("1", 0, 0, "t4.1b");
        step("=", 0, 1, "t4.=");
        chk("t4.done", 32'(done_a), 0);

        // 5: OP_MASK=0101 instance
        do_clr();
        send("1");
        chk("t5.1", 32'(out_c), 1);
        send("+");
        chk("t5.+", 32'(out_c), 0);
        send("2");
        chk("t5.2", 32'(out_c), 1);
        chk("t5.err", 32'(err_c), 0);
        do_clr();
        send("1");
        send("-");
        chk("t5.-.err", 32'(err_c), 1);
        chk("t5.-.def_err", 32'(err_a), 0);
        do_clr();
        send("1");
        send("/");
        chk("t5./.err", 32'(err_c), 1);
        send("*");
        chk("t5.*.sticky", 32'(err_c), 1);

        // 6: in_valid gaps with garbage on in
        do_clr();
        step("1", 1, 0, "t6.1");
        idle(8'h29); chk("t6.h1", 32'(out_a), 1);
        idle(8'hff); chk("t6.h2", 32'(out_a), 1);
        step("+", 0, 0, "t6.+");
        idle(8'h3d); chk("t6.h3", 32'(out_a), 0);
        idle(8'h00); chk("t6.h4", 32'(err_a), 0);
        step("2", 1, 0, "t6.2");
        idle(8'h28); chk("t6.h5", 32'(depth_a), 0);
        idle(8'h41); chk("t6.h6", 32'(out_a), 1);
        step("*", 0, 0, "t6.*");
        idle(8'h3d); chk("t6.h7", 32'(done_a), 0);
        idle(8'h39); chk("t6.h8", 32'(out_a), 0);
        step("0", 1, 0, "t6.0");
        do_clr();
        step("0", 1, 0, "t6.07.0");
        step("7", 0, 1, "t6.07.7");
        do_clr();
        step("0", 1, 0, "t6.010.0");
        step("+", 0, 0, "t6.010.+");
        step("1", 1, 0, "t6.010.1");
        step("0", 1, 0, "t6.010.0b");

        // leading '=', other chars, clr beating a valid character
        do_clr();
        step("=", 0, 1, "t7.=");
        do_clr();
        step("a", 0, 1, "t7.other");
        do_clr();
        in = "5";
        in_valid = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("t7.clrwin.out", 32'(out_a), 0);
        chk("t7.clrwin.err", 32'(err_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
